// File: rtl/data_mem_pkg.sv
// Shared definitions for the data RAM: access-size encodings, default base address
// and the helpers that turn (size, address LSBs) into byte-lane write enables and lane data.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            SZ_WORD: m = 4'b1111;
            SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: m = 4'b0001 << lo;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate the store LSBs across the word so any lane enable picks the right bits.
    function automatic logic [31:0] lane_data(size_e sz, logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (sz)
            SZ_WORD: r = d;
            SZ_HALF: r = {2{d[15:0]}};
            default: r = {4{d[7:0]}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// MEM-stage request/response bundle between the core (master) and the data RAM (slave).
interface data_mem_if;
    logic        mem_en;
    logic        mem_we;
    logic        mem_se;
    logic [3:0]  mem_bs;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output mem_en, mem_we, mem_se, mem_bs, addr, data_in,
        input  data_out
    );

    modport slave (
        input  mem_en, mem_we, mem_se, mem_bs, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/data_mem_load_ext.sv
// Selects the addressed lane of a RAM word and zero/sign-extends it to 32 bits.
module data_mem_load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        se,
    output logic [31:0] result
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        result = 32'h0;
        half   = lane[1] ? word[31:16] : word[15:0];
        byte_v = word[{lane, 3'b000} +: 8];
        case (size)
            SZ_WORD: result = word;
            SZ_HALF: result = {{16{se & half[15]}}, half};
            SZ_BYTE: result = {{24{se & byte_v[7]}}, byte_v};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data RAM for the MEM stage: synchronous lane-masked stores,
// registered extended loads with one-cycle latency.
module data_mem
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] word_idx;
    size_e         size;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   ext_word;
    logic [31:0]   data_out_d;
    logic [31:0]   data_out_q;
    logic          unused_bs;

    assign off      = bus.addr - BASE_ADDR;
    assign in_range = off < SPAN;
    assign word_idx = off[AW+1:2];
    assign size     = size_e'(bus.mem_bs[1:0]);
    assign unused_bs = ^bus.mem_bs[3:2];

    assign wr_be   = (bus.mem_en && bus.mem_we && in_range) ? lane_mask(size, off[1:0]) : 4'b0000;
    assign wr_data = lane_data(size, bus.data_in);

    // NOTE: the RAM array has no reset; contents survive rst_n so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) begin
                mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    data_mem_load_ext u_load_ext (
        .word   (mem[word_idx]),
        .lane   (off[1:0]),
        .size   (size),
        .se     (bus.mem_se),
        .result (ext_word)
    );

    always_comb begin
        data_out_d = 32'h0;
        if (!bus.mem_en) begin
            data_out_d = 32'h0;
        end else if (bus.mem_we) begin
            data_out_d = data_out_q;
        end else if (in_range) begin
            data_out_d = ext_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= 32'h0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios with literal expectations plus
// randomized traffic compared against a byte-array reference model.
module tb_data_mem;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          SPAN  = 4 * DEPTH;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_mem_if bus ();

    data_mem #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // Reference model: byte-addressed memory image and the expected load register.
    logic [7:0]  ref_mem [SPAN];
    logic [31:0] ref_out;

    function automatic logic [31:0] model_load(logic se, logic [1:0] sz, logic [31:0] a);
        logic [31:0]        o;
        int                 wb;
        int                 p;
        logic        [15:0] h;
        logic        [7:0]  b;
        logic signed [31:0] r;
        o = a - BASE;
        if (sz == 2'b00 || o >= 32'(SPAN)) return 32'h0;
        wb = int'(o) & ~3;
        case (sz)
            2'b11: return {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
            2'b10: begin
                p = wb + (o[1] ? 2 : 0);
                h = {ref_mem[p+1], ref_mem[p]};
                r = $signed(h);
                return se ? 32'(r) : {16'h0, h};
            end
            default: begin
                b = ref_mem[int'(o)];
                r = $signed(b);
                return se ? 32'(r) : {24'h0, b};
            end
        endcase
    endfunction

    task automatic model_store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        logic [31:0] o;
        int          wb;
        int          p;
        o = a - BASE;
        if (sz == 2'b00 || o >= 32'(SPAN)) return;
        wb = int'(o) & ~3;
        case (sz)
            2'b11: for (int k = 0; k < 4; k++) ref_mem[wb+k] = d[8*k +: 8];
            2'b10: begin
                p = wb + (o[1] ? 2 : 0);
                ref_mem[p]   = d[7:0];
                ref_mem[p+1] = d[15:8];
            end
            default: ref_mem[int'(o)] = d[7:0];
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, clock, update the model, compare against it.
    task automatic op(input string tag, input logic en, input logic we, input logic se,
                      input logic [3:0] bs, input logic [31:0] a, input logic [31:0] d);
        bus.mem_en  = en;
        bus.mem_we  = we;
        bus.mem_se  = se;
        bus.mem_bs  = bs;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (!en)      ref_out = 32'h0;
        else if (we)  model_store(bs[1:0], a, d);
        else          ref_out = model_load(se, bs[1:0], a);
        check(tag, bus.data_out, ref_out);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        int          sel;

        checks  = 0;
        errors  = 0;
        ref_out = 32'h0;
        rst_n   = 1'b0;
        bus.mem_en  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.mem_se  = 1'b0;
        bus.mem_bs  = 4'h0;
        bus.addr    = BASE;
        bus.data_in = 32'h0;
        #12;
        check("reset_out", bus.data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // en=0 blocks the write and clears the output
        op("sw_w0",     1, 1, 0, 4'h3, BASE, 32'h1111_1111);
        op("lw_w0",     1, 0, 0, 4'h3, BASE, 32'h0);
        check("lw_w0_lit", bus.data_out, 32'h1111_1111);
        op("en0_store", 0, 1, 0, 4'h3, BASE, 32'hAAAA_AAAA);
        check("en0_out", bus.data_out, 32'h0);
        op("lw_w0_keep", 1, 0, 0, 4'h3, BASE, 32'h0);
        check("en0_ram_kept", bus.data_out, 32'h1111_1111);

        // word store, word load, then each byte lane
        op("sw_10", 1, 1, 0, 4'h3, BASE + 32'h10, 32'h1234_5678);
        check("store_holds", bus.data_out, 32'h1111_1111);
        op("lw_10", 1, 0, 0, 4'h3, BASE + 32'h10, 32'h0);
        check("lw_10_lit", bus.data_out, 32'h1234_5678);
        op("lbu_10", 1, 0, 0, 4'h1, BASE + 32'h10, 32'h0);
        check("lbu_10_lit", bus.data_out, 32'h0000_0078);
        op("lbu_11", 1, 0, 0, 4'h1, BASE + 32'h11, 32'h0);
        check("lbu_11_lit", bus.data_out, 32'h0000_0056);
        op("lbu_12", 1, 0, 0, 4'h1, BASE + 32'h12, 32'h0);
        check("lbu_12_lit", bus.data_out, 32'h0000_0034);
        op("lbu_13", 1, 0, 0, 4'h1, BASE + 32'h13, 32'h0);
        check("lbu_13_lit", bus.data_out, 32'h0000_0012);

        // half store into upper lane of a zeroed word; ignored mem_bs[3:2]
        op("sw_20",  1, 1, 0, 4'h3, BASE + 32'h20, 32'h0);
        op("sh_22",  1, 1, 0, 4'hE, BASE + 32'h22, 32'h5555_BEEF);
        op("lw_20",  1, 0, 1, 4'h3, BASE + 32'h20, 32'h0);
        check("lw_20_lit", bus.data_out, 32'hBEEF_0000);
        op("lh_22",  1, 0, 1, 4'h2, BASE + 32'h22, 32'h0);
        check("lh_22_lit", bus.data_out, 32'hFFFF_BEEF);
        op("lhu_23", 1, 0, 0, 4'h2, BASE + 32'h23, 32'h0);
        check("lhu_23_lit", bus.data_out, 32'h0000_BEEF);

        // byte store leaves neighbours intact
        op("sw_04", 1, 1, 0, 4'h3, BASE + 32'h04, 32'hA1B2_C3D4);
        op("sb_05", 1, 1, 0, 4'h1, BASE + 32'h05, 32'hFFFF_FF80);
        op("lb_05", 1, 0, 1, 4'h1, BASE + 32'h05, 32'h0);
        check("lb_05_lit", bus.data_out, 32'hFFFF_FF80);
        op("lbu_05", 1, 0, 0, 4'h1, BASE + 32'h05, 32'h0);
        check("lbu_05_lit", bus.data_out, 32'h0000_0080);
        op("lw_04", 1, 0, 0, 4'h3, BASE + 32'h04, 32'h0);
        check("lw_04_lit", bus.data_out, 32'hA1B2_80D4);
        op("bs_none", 1, 0, 0, 4'h0, BASE + 32'h04, 32'h0);
        check("bs_none_lit", bus.data_out, 32'h0);

        // last word and first address past the end
        op("sw_last", 1, 1, 0, 4'h3, BASE + 32'(SPAN - 4), 32'hCAFE_F00D);
        op("lw_last", 1, 0, 0, 4'h3, BASE + 32'(SPAN - 4), 32'h0);
        check("lw_last_lit", bus.data_out, 32'hCAFE_F00D);
        op("sw_oor", 1, 1, 0, 4'h3, BASE + 32'(SPAN), 32'hDEAD_BEEF);
        op("lw_oor", 1, 0, 0, 4'h3, BASE + 32'(SPAN), 32'h0);
        check("lw_oor_lit", bus.data_out, 32'h0);
        op("lw_w0_nowrap", 1, 0, 0, 4'h3, BASE, 32'h0);
        check("oor_no_wrap", bus.data_out, 32'h1111_1111);

        // asynchronous reset mid-cycle, RAM retained
        op("lw_pre_rst", 1, 0, 0, 4'h3, BASE + 32'h10, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", bus.data_out, 32'h0);
        bus.mem_en = 1'b0;
        #2;
        rst_n   = 1'b1;
        ref_out = 32'h0;
        @(posedge clk);
        #1;
        op("lw_post_rst", 1, 0, 0, 4'h3, BASE + 32'h10, 32'h0);
        check("ram_after_rst", bus.data_out, 32'h1234_5678);

        // randomized traffic over an initialised window plus out-of-range probes
        for (int w = 0; w < 32; w++) begin
            op("rnd_init", 1, 1, 0, 4'h3, BASE + 32'(4 * w), $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = BASE + 32'(SPAN) + 32'($urandom_range(0, 255));
            else if (sel == 1) ra = BASE - 32'd1 - 32'($urandom_range(0, 255));
            else               ra = BASE + 32'($urandom_range(0, 127));
            rd = $urandom;
            op("rnd_op", ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), ra, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
